// File: rtl/ex_div_pkg.sv
// ============================================================================
// ex_div_pkg : shared types for the EX-stage iterative divider
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package ex_div_pkg;

  localparam int DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage : ex_div_pkg

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// ex_div : iterative restoring divider for MIPS DIV/DIVU, one bit per cycle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start_i,
  input  logic                  div_signed_i,
  input  logic                  div_annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_for_ex
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? negate(v) : v;
  endfunction

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*DATA_W:0]    work_q, work_d;
  logic [DATA_W-1:0]    divisor_q, divisor_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]  result_q, result_d;

  logic [2*DATA_W:0]    shift_w;
  logic [DATA_W:0]      trial_w;
  logic [2*DATA_W:0]    step_w;
  logic [DATA_W-1:0]    quo_w, rem_w;

  // Trial subtraction on the upper half; a borrow (MSB set) means keep the shifted value.
  always_comb begin
    shift_w = work_q << 1;
    trial_w = shift_w[2*DATA_W:DATA_W] - {1'b0, divisor_q};
    if (trial_w[DATA_W]) begin
      step_w = shift_w;
    end else begin
      step_w = {trial_w, shift_w[DATA_W-1:0]} | {{(2*DATA_W){1'b0}}, 1'b1};
    end
    quo_w = neg_quo_q ? negate(step_w[DATA_W-1:0]) : step_w[DATA_W-1:0];
    rem_w = neg_rem_q ? negate(step_w[2*DATA_W-1:DATA_W]) : step_w[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      DIV_FREE: begin
        if (div_start_i && !div_annul_i) begin
          cnt_d = '0;
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
            work_d  = {{(DATA_W+1){1'b0}}, opdata1_i};
          end else begin
            state_d   = DIV_ON;
            work_d    = {{(DATA_W+1){1'b0}}, abs_val(opdata1_i, div_signed_i)};
            divisor_d = abs_val(opdata2_i, div_signed_i);
            neg_rem_d = div_signed_i & opdata1_i[DATA_W-1];
            neg_quo_d = div_signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          end
        end
      end
      DIV_BYZERO: begin
        state_d  = DIV_END;
        result_d = {work_q[DATA_W-1:0], {DATA_W{1'b1}}};
      end
      DIV_ON: begin
        // A dropped start means EX no longer holds the divide; abandon it like an annul.
        if (div_annul_i || !div_start_i) begin
          state_d = DIV_FREE;
        end else begin
          work_d = step_w;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = DIV_END;
            result_d = {rem_w, quo_w};
          end
        end
      end
      DIV_END: begin
        state_d = DIV_FREE;
      end
      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  assign result_o        = result_q;
  assign ready_o         = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign stallreq_for_ex = div_start_i & ~div_annul_i & (state_q != DIV_END);

endmodule : ex_div

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
// tb_ex_div : self-checking bench for ex_div (directed table, sequences, random)
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module tb_ex_div;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           div_start_i;
  logic           div_signed_i;
  logic           div_annul_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stallreq_for_ex;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  ex_div #(.DATA_W(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .div_start_i     (div_start_i),
    .div_signed_i    (div_signed_i),
    .div_annul_i     (div_annul_i),
    .opdata1_i       (opdata1_i),
    .opdata2_i       (opdata2_i),
    .result_o        (result_o),
    .ready_o         (ready_o),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    int           lat;
  } vec_t;

  // Reference: plain 64-bit arithmetic; truncating division, remainder follows dividend.
  function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {a, {W{1'b1}}};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    div_start_i  = 1'b1;
    div_annul_i  = 1'b0;
    div_signed_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
  endtask

  // Called at the negedge of the start cycle; returns at the negedge of the ready cycle.
  task automatic run_to_ready(input int lat, input string name, output int at_cyc);
    int c;
    bit seen, stall_ok;
    c = 0; seen = 0; stall_ok = 1;
    while (!seen && c < 80) begin
      @(negedge clk);
      c++;
      if (ready_o) seen = 1;
      if (stallreq_for_ex !== logic'(c < lat)) stall_ok = 0;
    end
    at_cyc = cyc;
    chk({name, " latency"}, 64'(c), 64'(lat));
    chk({name, " stall profile"}, 64'(stall_ok), 64'd1);
  endtask

  task automatic one_div(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp, input int lat);
    int t;
    drive(sgn, a, b);
    run_to_ready(lat, name, t);
    chk({name, " result"}, result_o, exp);
    div_start_i = 1'b0;
    @(negedge clk);
    chk({name, " ready one-shot"}, 64'(ready_o), 64'd0);
  endtask

  task automatic quiet(input string name, input int n);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready_o) hits++;
    end
    chk({name, " no ready"}, 64'(hits), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int t1, t2;
    logic         rs;
    logic [W-1:0] ra, rb;

    vecs[0] = '{"divu 100/7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1] = '{"div -7/2",     1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   33};
    vecs[2] = '{"div 7/-2",     1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'h1,          33};
    vecs[3] = '{"div min/-1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0,          33};
    vecs[4] = '{"divu max/1",   1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'h0,          33};
    vecs[5] = '{"div by zero",  1'b1, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       2};
    vecs[6] = '{"divu min/max", 1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   33};

    rst = 1'b1;
    div_start_i = 1'b0; div_signed_i = 1'b0; div_annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    chk("reset result", result_o, 64'd0);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset stall", 64'(stallreq_for_ex), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      one_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
              {vecs[i].exp_r, vecs[i].exp_q}, vecs[i].lat);

    // Annul at iteration 10, then a clean divide must take the full 33 cycles.
    drive(1'b1, 32'd1000, 32'hFFFFFFFD);
    repeat (10) @(negedge clk);
    div_annul_i = 1'b1;
    #1 chk("annul stall drop", 64'(stallreq_for_ex), 64'd0);
    @(negedge clk);
    div_start_i = 1'b0; div_annul_i = 1'b0;
    quiet("annul", 40);
    one_div("after annul", 1'b1, 32'd1000, 32'hFFFFFFFD, model(1'b1, 32'd1000, 32'hFFFFFFFD), 33);

    // Start withdrawn mid-divide behaves as an annul.
    drive(1'b0, 32'd5000, 32'd9);
    repeat (5) @(negedge clk);
    div_start_i = 1'b0;
    quiet("start drop", 40);

    // Back-to-back: second start held in the cycle after END.
    drive(1'b0, 32'd100, 32'd7);
    run_to_ready(33, "b2b first", t1);
    chk("b2b first result", result_o, {32'd2, 32'd14});
    drive(1'b1, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    run_to_ready(33, "b2b second", t2);
    chk("b2b spacing", 64'(t2 - t1), 64'd34);
    chk("b2b second result", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    div_start_i = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    drive(1'b0, 32'hDEADBEEF, 32'd3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst result", result_o, 64'd0);
    chk("async rst ready", 64'(ready_o), 64'd0);
    div_start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    quiet("after rst", 40);
    one_div("after rst div", 1'b0, 32'hDEADBEEF, 32'd3, model(1'b0, 32'hDEADBEEF, 32'd3), 33);

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      one_div($sformatf("rand%0d s=%0d %h/%h", n, rs, ra, rb), rs, ra, rb,
              model(rs, ra, rb), (rb == '0) ? 2 : 33);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_ex_div

`default_nettype wire
